// File: rtl/rp_gen_calib_pkg.sv
// Shared constants for the generator calibration path: unity gain, gain scaling
// and pipeline depth.
package rp_gen_calib_pkg;

  localparam logic [15:0] CALIB_UNITY_GAIN = 16'h8000;
  localparam int          CALIB_GAIN_SHIFT = 15;
  localparam int          CALIB_LATENCY    = 3;

endpackage

// File: rtl/rp_sat.sv
// Signed saturating narrower: clips an IW-bit value into the OW-bit range and
// flags when clipping happened.
module rp_sat #(
  parameter int IW = 16,
  parameter int OW = 14
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 sat
);

  localparam logic signed [OW-1:0] MAX_VAL = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MIN_VAL = {1'b1, {(OW-1){1'b0}}};

  logic [IW-OW:0] top_bits;
  assign top_bits = din[IW-1:OW-1];

  // The value fits only if every bit above the output sign bit repeats it.
  always_comb begin
    dout = din[OW-1:0];
    sat  = 1'b0;
    if (top_bits != {(IW-OW+1){din[IW-1]}}) begin
      sat  = 1'b1;
      dout = din[IW-1] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/rp_gen_calib.sv
// DAC-side calibration: gain then offset, three-stage stall-able pipeline with
// per-sample saturation flag and a sticky saturation counter.
module rp_gen_calib
  import rp_gen_calib_pkg::*;
#(
  parameter int DBITS   = 14,
  parameter int CNTBITS = 16
) (
  input  logic                    dac_clk_i,
  input  logic                    dac_rstn_i,
  input  logic signed [DBITS-1:0] gen_dat_i,
  input  logic                    gen_din_tvalid_i,
  output logic                    gen_din_tready_o,
  output logic signed [DBITS-1:0] gen_dat_o,
  output logic                    gen_dout_tvalid_o,
  input  logic                    gen_dout_tready_i,
  input  logic signed [DBITS-1:0] cfg_calib_offset_i,
  input  logic [15:0]             cfg_calib_gain_i,
  input  logic                    cfg_update_i,
  output logic [CNTBITS-1:0]      sat_cnt_o,
  input  logic                    sat_cnt_clr_i
);

  logic                     en;
  logic [15:0]              gain_q;
  logic signed [DBITS-1:0]  offset_q;
  logic [CALIB_LATENCY-1:0] vld_q;

  logic signed [DBITS+16:0] prod_q;
  logic signed [DBITS+16:0] prod_shifted;
  logic signed [DBITS-1:0]  gain_clip;
  logic                     gain_sat;
  logic signed [DBITS-1:0]  g_q;
  logic                     sat2_q;

  logic signed [DBITS:0]    sum;
  logic signed [DBITS-1:0]  sum_clip;
  logic                     sum_sat;
  logic                     sat3_q;

  assign en                = !gen_dout_tvalid_o || gen_dout_tready_i;
  assign gen_din_tready_o  = en;
  assign gen_dout_tvalid_o = vld_q[CALIB_LATENCY-1];

  // Shadow config loads independently of the data pipeline stalls.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      gain_q   <= CALIB_UNITY_GAIN;
      offset_q <= '0;
    end else if (cfg_update_i) begin
      gain_q   <= cfg_calib_gain_i;
      offset_q <= cfg_calib_offset_i;
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[CALIB_LATENCY-2:0], gen_din_tvalid_i};
    end
  end

  // Stage 1: bare multiply into a register so it maps onto a DSP block.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      prod_q <= '0;
    end else if (en) begin
      prod_q <= gen_dat_i * $signed({1'b0, gain_q});
    end
  end

  assign prod_shifted = prod_q >>> CALIB_GAIN_SHIFT;

  rp_sat #(
    .IW (DBITS+17),
    .OW (DBITS)
  ) u_sat_gain (
    .din  (prod_shifted),
    .dout (gain_clip),
    .sat  (gain_sat)
  );

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      g_q    <= '0;
      sat2_q <= 1'b0;
    end else if (en) begin
      g_q    <= gain_clip;
      sat2_q <= gain_sat;
    end
  end

  assign sum = {g_q[DBITS-1], g_q} + {offset_q[DBITS-1], offset_q};

  rp_sat #(
    .IW (DBITS+1),
    .OW (DBITS)
  ) u_sat_offset (
    .din  (sum),
    .dout (sum_clip),
    .sat  (sum_sat)
  );

  // Output data only moves for real samples so it holds across bubbles.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      gen_dat_o <= '0;
      sat3_q    <= 1'b0;
    end else if (en && vld_q[1]) begin
      gen_dat_o <= sum_clip;
      sat3_q    <= sat2_q | sum_sat;
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      sat_cnt_o <= '0;
    end else if (sat_cnt_clr_i) begin
      sat_cnt_o <= '0;
    end else if (gen_dout_tvalid_o && gen_dout_tready_i && sat3_q &&
                 (sat_cnt_o != {CNTBITS{1'b1}})) begin
      sat_cnt_o <= sat_cnt_o + CNTBITS'(1);
    end
  end

endmodule

// File: tb/tb_rp_gen_calib.sv
// Scoreboard bench for rp_gen_calib: stimulus pushes accepted samples, a
// negedge monitor computes the calibrated value from plain arithmetic.
module tb_rp_gen_calib;

  localparam int DMAX = 8191;
  localparam int DMIN = -8192;

  logic               dac_clk_i = 1'b0;
  logic               dac_rstn_i;
  logic signed [13:0] gen_dat_i;
  logic               gen_din_tvalid_i;
  logic               gen_din_tready_o;
  logic signed [13:0] gen_dat_o;
  logic               gen_dout_tvalid_o;
  logic               gen_dout_tready_i;
  logic signed [13:0] cfg_calib_offset_i;
  logic [15:0]        cfg_calib_gain_i;
  logic               cfg_update_i;
  logic [15:0]        sat_cnt_o;
  logic               sat_cnt_clr_i;

  rp_gen_calib #(.DBITS(14), .CNTBITS(16)) dut (
    .dac_clk_i          (dac_clk_i),
    .dac_rstn_i         (dac_rstn_i),
    .gen_dat_i          (gen_dat_i),
    .gen_din_tvalid_i   (gen_din_tvalid_i),
    .gen_din_tready_o   (gen_din_tready_o),
    .gen_dat_o          (gen_dat_o),
    .gen_dout_tvalid_o  (gen_dout_tvalid_o),
    .gen_dout_tready_i  (gen_dout_tready_i),
    .cfg_calib_offset_i (cfg_calib_offset_i),
    .cfg_calib_gain_i   (cfg_calib_gain_i),
    .cfg_update_i       (cfg_update_i),
    .sat_cnt_o          (sat_cnt_o),
    .sat_cnt_clr_i      (sat_cnt_clr_i)
  );

  always #5 dac_clk_i = ~dac_clk_i;

  typedef struct {
    int data;
    int gain;
  } item_t;

  item_t exp_q[$];
  item_t it;
  int    tests = 0;
  int    fails = 0;

  int sh_gain, sh_off, pend_gain, pend_off, off_prev;
  bit pend;
  bit next_new;
  int cur_exp;
  bit cur_flag;
  int last_dat;
  int sat_model;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int clipTo(input longint v, inout bit s);
    if (v > DMAX) begin s = 1'b1; return DMAX; end
    if (v < DMIN) begin s = 1'b1; return DMIN; end
    return int'(v);
  endfunction

  // Gain in Q1.15 with floor rounding, then offset, each clipped to 14 bits.
  function automatic int refCalc(input int data, input int gain, input int off, output bit sat);
    longint p, g;
    p = longint'(data) * longint'(gain);
    g = p / 32768;
    if (p < 0 && (p % 32768) != 0) g = g - 1;
    sat = 1'b0;
    g = clipTo(g, sat);
    return clipTo(g + off, sat);
  endfunction

  // Monitor and reference model, evaluated mid-cycle on stable signals.
  always @(negedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      exp_q.delete();
      sh_gain   = 32768;
      sh_off    = 0;
      pend      = 1'b0;
      off_prev  = 0;
      next_new  = 1'b1;
      last_dat  = 0;
      cur_flag  = 1'b0;
      sat_model = 0;
      checkOutput("rst_dout_tvalid", gen_dout_tvalid_o, 0);
      checkOutput("rst_dout_data", gen_dat_o, 0);
      checkOutput("rst_sat_cnt", sat_cnt_o, 0);
      checkOutput("rst_din_tready", gen_din_tready_o, 1);
    end else begin
      if (pend) begin
        sh_gain = pend_gain;
        sh_off  = pend_off;
        pend    = 1'b0;
      end
      checkOutput("sat_cnt", sat_cnt_o, sat_model);
      checkOutput("din_tready", gen_din_tready_o, !gen_dout_tvalid_o || gen_dout_tready_i);
      if (gen_dout_tvalid_o) begin
        if (next_new) begin
          checkOutput("output_was_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            cur_exp = refCalc(it.data, it.gain, off_prev, cur_flag);
          end else begin
            cur_flag = 1'b0;
          end
        end
        checkOutput("dout_data", gen_dat_o, cur_exp);
        last_dat = cur_exp;
        next_new = gen_dout_tready_i;
      end else begin
        checkOutput("dout_hold", gen_dat_o, last_dat);
        next_new = 1'b1;
      end
      if (sat_cnt_clr_i) sat_model = 0;
      else if (gen_dout_tvalid_o && gen_dout_tready_i && cur_flag && sat_model != 65535)
        sat_model = sat_model + 1;
      if (gen_din_tvalid_i && gen_din_tready_o)
        exp_q.push_back('{data: int'(gen_dat_i), gain: sh_gain});
      if (cfg_update_i) begin
        pend      = 1'b1;
        pend_gain = int'(cfg_calib_gain_i);
        pend_off  = int'(cfg_calib_offset_i);
      end
      off_prev = sh_off;
    end
  end

  task automatic tick;
    @(posedge dac_clk_i);
    #1;
  endtask

  task automatic setCfg(input int gain, input int off);
    cfg_calib_gain_i   = gain[15:0];
    cfg_calib_offset_i = off[13:0];
    cfg_update_i       = 1'b1;
    tick();
    cfg_update_i       = 1'b0;
  endtask

  // Single sample into an empty pipeline, checking the three-cycle latency.
  task automatic sendOne(input int d, input int expected);
    gen_dout_tready_i = 1'b1;
    gen_din_tvalid_i  = 1'b1;
    gen_dat_i         = d[13:0];
    tick();
    gen_din_tvalid_i  = 1'b0;
    @(negedge dac_clk_i);
    @(negedge dac_clk_i);
    checkOutput("latency_not_early", gen_dout_tvalid_o, 0);
    @(negedge dac_clk_i);
    checkOutput("latency_valid", gen_dout_tvalid_o, 1);
    checkOutput("latency_data", gen_dat_o, expected);
    tick();
  endtask

  // mode 0: ramp with a 5-cycle backpressure window; 1: random everything;
  // 2: ramp, ready high, optional offset update and/or reset at given cycles.
  task automatic applyStimulus(input int n, input int mode, input int cfg_at, input int rst_at);
    int idx = 0;
    int cyc = 0;
    int d;
    bit acc;
    while (idx < n && cyc < 2000) begin
      d = (mode == 1) ? int'($urandom_range(0, 16383)) - 8192 : idx;
      gen_dat_i        = d[13:0];
      gen_din_tvalid_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      case (mode)
        0:       gen_dout_tready_i = !(cyc >= 5 && cyc < 10);
        1:       gen_dout_tready_i = ($urandom_range(0, 3) != 0);
        default: gen_dout_tready_i = 1'b1;
      endcase
      cfg_update_i = 1'b0;
      if (cyc == cfg_at) begin
        cfg_calib_offset_i = 14'sd50;
        cfg_update_i       = 1'b1;
      end else if (mode == 1 && $urandom_range(0, 11) == 0) begin
        cfg_calib_gain_i   = 16'($urandom_range(0, 65535));
        cfg_calib_offset_i = 14'($urandom_range(0, 16383));
        cfg_update_i       = 1'b1;
      end
      if (cyc == rst_at)     dac_rstn_i = 1'b0;
      if (cyc == rst_at + 2) dac_rstn_i = 1'b1;
      @(negedge dac_clk_i);
      acc = gen_din_tvalid_i && gen_din_tready_o && dac_rstn_i;
      if (mode == 0 && cyc == 7) checkOutput("stall_din_tready", gen_din_tready_o, 0);
      tick();
      if (acc) idx++;
      cyc++;
    end
    checkOutput("stream_complete", idx, n);
    gen_din_tvalid_i = 1'b0;
    cfg_update_i     = 1'b0;
    dac_rstn_i       = 1'b1;
  endtask

  task automatic drain;
    int k = 0;
    gen_dout_tready_i = 1'b1;
    while ((exp_q.size() != 0 || gen_dout_tvalid_o) && k < 40) begin
      tick();
      k++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    dac_rstn_i         = 1'b0;
    gen_dat_i          = '0;
    gen_din_tvalid_i   = 1'b0;
    gen_dout_tready_i  = 1'b1;
    cfg_calib_offset_i = '0;
    cfg_calib_gain_i   = 16'h8000;
    cfg_update_i       = 1'b0;
    sat_cnt_clr_i      = 1'b0;
    repeat (3) tick();
    dac_rstn_i = 1'b1;
    tick();

    sendOne(1000, 1000);
    drain();
    checkOutput("unity_sat_cnt", sat_cnt_o, 0);

    setCfg(16'h4000, 100);
    sendOne(-8000, -3900);
    drain();

    setCfg(16'hFFFF, 0);
    sendOne(8000, 8191);
    drain();
    checkOutput("sat_cnt_after_gain_clip", sat_cnt_o, 1);
    setCfg(16'h8000, -8192);
    sendOne(-100, -8192);
    drain();
    checkOutput("sat_cnt_after_offset_clip", sat_cnt_o, 2);

    setCfg(16'h8000, 0);
    applyStimulus(10, 0, -1, -1);
    drain();

    applyStimulus(16, 2, 6, -1);
    drain();

    for (int r = 0; r < 4; r++) begin
      setCfg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 16383)) - 8192);
      applyStimulus(60, 1, -1, -1);
      drain();
    end

    setCfg(16'hFFFF, 0);
    applyStimulus(20, 2, -1, 8);
    drain();

    setCfg(16'hFFFF, 0);
    gen_dout_tready_i = 1'b0;
    gen_din_tvalid_i  = 1'b1;
    gen_dat_i         = 14'sd8000;
    tick();
    gen_din_tvalid_i  = 1'b0;
    repeat (4) tick();
    checkOutput("held_saturated_valid", gen_dout_tvalid_o, 1);
    sat_cnt_clr_i     = 1'b1;
    gen_dout_tready_i = 1'b1;
    tick();
    sat_cnt_clr_i     = 1'b0;
    checkOutput("clear_wins_over_increment", sat_cnt_o, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rp_gen_calib.md
RP_GEN_CALIB -- requirements
Module: rp_gen_calib

Interface
REQ-001 SHALL have parameter DBITS, default 14, giving the DAC sample width (two's complement).
REQ-002 SHALL have parameter CNTBITS, default 16, giving the saturation counter width.
REQ-003 dac_clk_i  in  1  single clock for all logic.
REQ-004 dac_rstn_i  in  1  asynchronous, active-low reset.
REQ-005 gen_dat_i  in  DBITS  uncalibrated signed sample from the generator buffer.
REQ-006 gen_din_tvalid_i  in  1  input sample valid.
REQ-007 gen_din_tready_o  out  1  input sample accepted when high together with tvalid.
REQ-008 gen_dat_o  out  DBITS  calibrated signed sample to the DAC.
REQ-009 gen_dout_tvalid_o  out  1  output sample valid.
REQ-010 gen_dout_tready_i  in  1  downstream ready.
REQ-011 cfg_calib_offset_i  in  DBITS  signed offset, in LSBs.
REQ-012 cfg_calib_gain_i  in  16  unsigned gain, 0x8000 = 1.0, 0xFFFF ~ 2.0.
REQ-013 cfg_update_i  in  1  single-cycle pulse; loads both config inputs into shadow registers.
REQ-014 sat_cnt_o  out  CNTBITS  count of output samples that were clipped.
REQ-015 sat_cnt_clr_i  in  1  synchronous clear of sat_cnt_o.

Function
REQ-016 SHALL apply gain first, then offset (inverse order of the scope path).
- Stage 1: prod = data * gain, signed × unsigned, full width DBITS+17.
- Stage 2: g = prod >>> 15 (arithmetic, truncate toward -inf), clipped to [-2^(DBITS-1), 2^(DBITS-1)-1].
- Stage 3: s = g + offset at DBITS+1 bits, clipped to the same range, registered to gen_dat_o.
REQ-017 SHALL use three pipeline stages: a sample accepted in cycle N appears on gen_dat_o with gen_dout_tvalid_o high in cycle N+3 when there is no backpressure.
REQ-018 Each stage SHALL carry its own valid bit; the common advance enable is en = !gen_dout_tvalid_o || gen_dout_tready_i.
REQ-019 gen_din_tready_o SHALL equal en, combinationally.
REQ-020 When en is low, all stage registers and outputs SHALL hold; no sample is lost or duplicated.
REQ-021 Pipeline bubbles (invalid stages) SHALL propagate as tvalid low; gen_dat_o SHALL hold its last value while invalid.
REQ-022 Shadow gain/offset SHALL update in the cycle after a cfg_update_i pulse, regardless of en.
- Every sample uses the shadow values present when it passes the respective stage.
REQ-023 Saturation flag SHALL ride with each sample: set if stage 2 or stage 3 clipped.
REQ-024 sat_cnt_o SHALL increment by 1 on each output handshake (gen_dout_tvalid_o && gen_dout_tready_i) whose sample carries the flag, and SHALL stick at its all-ones value.
REQ-025 If sat_cnt_clr_i and an increment coincide, clear SHALL win (result 0).

Reset
REQ-026 Reset SHALL force: all valid bits 0, gen_dout_tvalid_o 0, gen_dat_o 0, sat_cnt_o 0, shadow gain 0x8000, shadow offset 0.
REQ-027 gen_din_tready_o SHALL be 1 during and after reset (pipeline empty).
REQ-028 Reset asserted mid-stream SHALL discard in-flight samples; the first output after release is a sample accepted after release.

Structure
REQ-029 The shared package SHALL hold: the unity-gain constant 0x8000, the gain shift 15, and the pipeline latency 3.
REQ-030 Clipping SHALL be a single sub-module, rp_sat, parameterised by input and output width, instantiated at stages 2 and 3.
REQ-031 The multiplier output SHALL be registered (stage 1) with no logic between the multiplier and its register, for DSP inference.

Verification (DBITS=14, limits +8191/-8192)
REQ-032 Gain 0x8000, offset 0, data 1000, tready high -> 1000 three cycles later; sat_cnt 0.
REQ-033 Gain 0x4000, offset 100, data -8000 -> -3900.
REQ-034 Gain 0xFFFF, offset 0, data 8000 -> 8191, sat_cnt 1; gain 0x8000, offset -8192, data -100 -> -8192, sat_cnt 2.
REQ-035 Stream ramp 0..9, drop tready for 5 cycles with 3 samples in flight -> gen_dat_o stable, gen_din_tready_o low, outputs exactly 0..9 in order.
REQ-036 cfg_update_i pulse with offset 50 mid-stream -> later samples shift by 50 from the first sample that passes stage 3 after the update; no glitch values.
REQ-037 Reset pulse mid-stream and clear coincident with a saturated handshake -> REQ-026/028 values; sat_cnt reads 0.
